genius_core: RTL and testbench
==============================

Name: genius_core

Overview:
Parametrised Genius/Simon game engine. It generates a pseudo-random colour sequence, plays it back on one-hot lamps, and checks the player's button presses against it, adding one element per completed round. Seven-segment decoding and button debouncing are done by separate blocks around it; this block owns the game FSM, the sequence memory and all timing.

Parameters:
N_BUTTONS, 3, number of colours/buttons, legal range 2..8; IDX_W = clog2(N_BUTTONS) is derived.
MAX_LEN, 16, sequence length needed to win, legal range 2..64; LEN_W = clog2(MAX_LEN+1) is derived.
SHOW_ON_CYC, 4, clock cycles each lamp stays lit during playback (>=1).
SHOW_OFF_CYC, 2, dark gap after each lamp (>=1).
INPUT_TIMEOUT, 64, idle cycles allowed between presses before a loss (>=2).
SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
clock  in  1  system clock, all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a new game (honoured only in IDLE, WIN or LOSE)
btn  in  N_BUTTONS  one-cycle press pulses, already debounced and synchronised
lamp  out  N_BUTTONS  one-hot playback lamp, registered
level  out  LEN_W  current sequence length (0 before the first round)
busy  out  1  high in every state except IDLE, WIN and LOSE
win  out  1  held high in WIN
lose  out  1  held high in LOSE
state_out  out  3  encoded state: IDLE=0, LEVEL_UP=1, SHOW_ON=2, SHOW_OFF=3, WAIT_INPUT=4, WIN=5, LOSE=6

Behaviour:
- Reset (async, reset_n=0): state=IDLE, lamp=0, level=0, win=0, lose=0, pos=0, timer=0, lfsr=SEED. Sequence memory is not cleared. Reset mid-game aborts the game immediately.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in every state.
- New element: e = lfsr[IDX_W-1:0]; if e >= N_BUTTONS then e = e - N_BUTTONS. Result always lies in 0..N_BUTTONS-1.
- IDLE: lamp=0. start -> LEVEL_UP; level<=0, win<=0, lose<=0.
- LEVEL_UP (1 cycle): mem[level]<=e; level<=level+1; pos<=0; cnt<=0 -> SHOW_ON.
- SHOW_ON: lamp = onehot(mem[pos]) for exactly SHOW_ON_CYC cycles -> SHOW_OFF.
- SHOW_OFF: lamp=0 for SHOW_OFF_CYC cycles.
  - If pos==level-1: go to WAIT_INPUT with pos<=0, timer<=0.
  - Otherwise: pos<=pos+1 and return to SHOW_ON.
- btn is ignored in LEVEL_UP, SHOW_ON and SHOW_OFF.
- WAIT_INPUT: lamp=0.
  - btn==0: timer increments; timer==INPUT_TIMEOUT-1 -> LOSE.
  - btn is exactly one-hot and equals onehot(mem[pos]):
    - if pos==level-1 and level==MAX_LEN -> WIN;
    - if pos==level-1 and level<MAX_LEN -> LEVEL_UP;
    - otherwise pos<=pos+1, timer<=0.
  - Any other nonzero btn (wrong colour or multiple bits) -> LOSE.
  - A press and the timeout in the same cycle: the press takes priority.
- WIN: win=1, lamp=all ones. LOSE: lose=1, lamp=0. level holds its last value in both. start -> LEVEL_UP as from IDLE; level, win and lose are cleared in the same edge.
- start in any busy state is ignored.
- Latency: start at edge k gives LEVEL_UP during cycle k+1 and the first lamp lit from edge k+2.
- A round of length L plays back in L*(SHOW_ON_CYC+SHOW_OFF_CYC) cycles.

Test Plan:
1. Reset then idle 10 cycles -> lamp=0, level=0, busy=0, state_out=0. Assert reset_n=0 mid-SHOW_ON -> all outputs return to reset values asynchronously, before the next clock edge.
2. Defaults, start pulse -> level=1 one edge later; lamp one-hot for exactly 4 cycles, then 0 for 2 cycles; then state_out=4. Press the matching btn -> level=2; playback of 2 elements lasts 12 cycles and the first element matches round 1.
3. In WAIT_INPUT at level 2, press the correct first colour, then a wrong colour -> lose=1, state_out=6, level stays 2. Pressing btn afterwards has no effect; start -> level=1, lose=0.
4. In WAIT_INPUT, no press for 63 cycles -> lose asserts on the 63rd cycle. Repeat with a correct press on cycle 62 -> no loss and timer restarts.
5. MAX_LEN=2, N_BUTTONS=4: play both rounds correctly (model mirrors LFSR/element rule) -> win=1, lamp=4'b1111, level=2, busy=0. A two-bit btn during WAIT_INPUT in a separate run -> LOSE.
6. Pulse start during SHOW_OFF -> ignored, playback unchanged. N_BUTTONS=3 over 1000 LEVEL_UPs -> every stored element is in 0..2.

Source files
------------

// File: rtl/genius_core.sv
// Genius/Simon game engine: LFSR-driven colour sequence, timed lamp playback
// and checking of the player's presses, growing the sequence one step per round.
module genius_core #(
   parameter int N_BUTTONS     = 3,
   parameter int MAX_LEN       = 16,
   parameter int SHOW_ON_CYC   = 4,
   parameter int SHOW_OFF_CYC  = 2,
   parameter int INPUT_TIMEOUT = 64,
   parameter logic [15:0] SEED = 16'hACE1,
   localparam int IDX_W = $clog2(N_BUTTONS),
   localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [N_BUTTONS-1:0] btn,
   output logic [N_BUTTONS-1:0] lamp,
   output logic [LEN_W-1:0]     level,
   output logic                 busy,
   output logic                 win,
   output logic                 lose,
   output logic [2:0]           state_out
);

   localparam int ADDR_W  = $clog2(MAX_LEN);
   localparam int CNT_MAX = (SHOW_ON_CYC > SHOW_OFF_CYC) ? SHOW_ON_CYC : SHOW_OFF_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TMR_W   = $clog2(INPUT_TIMEOUT);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(SHOW_ON_CYC - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(SHOW_OFF_CYC - 1);
   // timer holds idle cycles already elapsed; an idle cycle seen with this
   // value would bring it to INPUT_TIMEOUT-1, which is the loss
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(INPUT_TIMEOUT - 2);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
   localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_BUTTONS);
   localparam logic [IDX_W-1:0] N_TRUNC  = IDX_W'(N_BUTTONS);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LEVEL_UP = 3'd1,
      S_SHOW_ON  = 3'd2,
      S_SHOW_OFF = 3'd3,
      S_WAIT     = 3'd4,
      S_WIN      = 3'd5,
      S_LOSE     = 3'd6
   } state_t;

   state_t            state;
   logic [15:0]       lfsr;
   logic [LEN_W-1:0]  pos;
   logic [CNT_W-1:0]  cnt;
   logic [TMR_W-1:0]  timer;
   logic [IDX_W-1:0]  mem [MAX_LEN];

   logic              lfsr_fb;
   logic [IDX_W-1:0]  raw_elem;
   logic [IDX_W-1:0]  new_elem;
   logic [IDX_W-1:0]  cur_elem;
   logic [IDX_W-1:0]  next_elem;
   logic [IDX_W-1:0]  first_elem;
   logic [LEN_W-1:0]  pos_inc;
   logic              pos_last;

   function automatic logic [N_BUTTONS-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot = {{(N_BUTTONS-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign raw_elem = lfsr[IDX_W-1:0];

   // fold out-of-range LFSR values back into 0..N_BUTTONS-1
   always_comb begin
      new_elem = raw_elem;
      if ({1'b0, raw_elem} >= N_EXT)
         new_elem = raw_elem - N_TRUNC;
   end

   assign pos_inc    = pos + LEN_W'(1);
   assign pos_last   = (pos == level - LEN_W'(1));
   assign cur_elem   = mem[pos[ADDR_W-1:0]];
   assign next_elem  = mem[pos_inc[ADDR_W-1:0]];
   // the element being appended in round 1 is not in memory yet
   assign first_elem = (level == '0) ? new_elem : mem[0];

   assign busy      = !(state == S_IDLE || state == S_WIN || state == S_LOSE);
   assign state_out = state;

   always_ff @(posedge clock) begin
      if (state == S_LEVEL_UP)
         mem[level[ADDR_W-1:0]] <= new_elem;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         lamp  <= '0;
         level <= '0;
         win   <= 1'b0;
         lose  <= 1'b0;
         pos   <= '0;
         cnt   <= '0;
         timer <= '0;
         lfsr  <= SEED;
      end else begin
         lfsr <= {lfsr_fb, lfsr[15:1]};
         case (state)
            S_IDLE, S_WIN, S_LOSE: begin
               if (start) begin
                  state <= S_LEVEL_UP;
                  level <= '0;
                  win   <= 1'b0;
                  lose  <= 1'b0;
                  lamp  <= '0;
               end
            end
            S_LEVEL_UP: begin
               level <= level + LEN_W'(1);
               pos   <= '0;
               cnt   <= '0;
               lamp  <= onehot(first_elem);
               state <= S_SHOW_ON;
            end
            S_SHOW_ON: begin
               if (cnt == ON_LAST) begin
                  cnt   <= '0;
                  lamp  <= '0;
                  state <= S_SHOW_OFF;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_SHOW_OFF: begin
               if (cnt == OFF_LAST) begin
                  cnt <= '0;
                  if (pos_last) begin
                     pos   <= '0;
                     timer <= '0;
                     state <= S_WAIT;
                  end else begin
                     pos   <= pos_inc;
                     lamp  <= onehot(next_elem);
                     state <= S_SHOW_ON;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (btn == '0) begin
                  if (timer == TMO_LAST) begin
                     lose  <= 1'b1;
                     state <= S_LOSE;
                  end else begin
                     timer <= timer + TMR_W'(1);
                  end
               end else if (btn == onehot(cur_elem)) begin
                  if (pos_last) begin
                     if (level == LEN_MAX) begin
                        win   <= 1'b1;
                        lamp  <= '1;
                        state <= S_WIN;
                     end else begin
                        state <= S_LEVEL_UP;
                     end
                  end else begin
                     pos   <= pos_inc;
                     timer <= '0;
                  end
               end else begin
                  lose  <= 1'b1;
                  state <= S_LOSE;
               end
            end
            default: begin
               state <= S_IDLE;
               lamp  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_genius_core.sv
// Directed bench for genius_core: a default instance (3 colours, 16 rounds)
// and a small instance (4 colours, 2 rounds) for the win path.
`timescale 1ns/1ps
module tb_genius_core;

   logic       clock = 1'b0;
   logic       reset_n;
   always #5 clock = ~clock;

   logic       start_a;
   logic [2:0] btn_a, lamp_a, state_a;
   logic [4:0] level_a;
   logic       busy_a, win_a, lose_a;

   logic       start_b;
   logic [3:0] btn_b, lamp_b;
   logic [1:0] level_b;
   logic [2:0] state_b;
   logic       busy_b, win_b, lose_b;

   genius_core u_dut_a (
      .clock(clock), .reset_n(reset_n), .start(start_a), .btn(btn_a),
      .lamp(lamp_a), .level(level_a), .busy(busy_a), .win(win_a),
      .lose(lose_a), .state_out(state_a)
   );

   genius_core #(.N_BUTTONS(4), .MAX_LEN(2)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .start(start_b), .btn(btn_b),
      .lamp(lamp_b), .level(level_b), .busy(busy_b), .win(win_b),
      .lose(lose_b), .state_out(state_b)
   );

   int total = 0;
   int bad   = 0;
   int seq_a [0:63];
   int seq_b [0:63];

   // reference LFSR: both instances share clock and reset, so one model serves both
   logic [15:0] m_lfsr;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) m_lfsr <= 16'hACE1;
      else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   function automatic int elem(input logic [15:0] l, input int n);
      int w, e;
      w = (n > 4) ? 3 : ((n > 2) ? 2 : 1);
      e = int'(l) & ((1 << w) - 1);
      if (e >= n) e = e - n;
      return e;
   endfunction

   function automatic logic [2:0] oh3(input int e);
      return 3'(1 << e);
   endfunction

   function automatic logic [3:0] oh4(input int e);
      return 4'(1 << e);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start_a = 1'b0; btn_a = '0; start_b = 1'b0; btn_b = '0;
      tick(3);
      reset_n = 1'b1;
      tick(10);
      total++; if (lamp_a !== 3'b000) begin bad++; $display("FAIL reset_lamp got=%0h want=0", lamp_a); end
      total++; if (level_a !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_a); end
      total++; if (state_a !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_a); end
      total++; if ({win_a, lose_a} !== 2'b00) begin bad++; $display("FAIL reset_winlose got=%b want=00", {win_a, lose_a}); end
      total++; if (state_b !== 3'd0) begin bad++; $display("FAIL reset_state_b got=%0d want=0", state_b); end
   endtask

   task automatic test_playback;
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      seq_a[0] = elem(m_lfsr, 3);
      total++; if (state_a !== 3'd1 || level_a !== 5'd0) begin bad++; $display("FAIL start_levelup got state=%0d level=%0d want state=1 level=0", state_a, level_a); end
      tick(1);
      total++; if (level_a !== 5'd1) begin bad++; $display("FAIL level_one got=%0d want=1", level_a); end
      for (int c = 0; c < 4; c++) begin
         total++; if (lamp_a !== oh3(seq_a[0])) begin bad++; $display("FAIL r1_lamp_on cyc=%0d got=%b want=%b", c, lamp_a, oh3(seq_a[0])); end
         tick(1);
      end
      for (int c = 0; c < 2; c++) begin
         total++; if (lamp_a !== 3'b000 || state_a !== 3'd3) begin bad++; $display("FAIL r1_lamp_off cyc=%0d got lamp=%b state=%0d want lamp=000 state=3", c, lamp_a, state_a); end
         tick(1);
      end
      total++; if (state_a !== 3'd4) begin bad++; $display("FAIL r1_wait got=%0d want=4", state_a); end
      btn_a = oh3(seq_a[0]);
      tick(1);
      btn_a = '0;
      seq_a[1] = elem(m_lfsr, 3);
      total++; if (state_a !== 3'd1) begin bad++; $display("FAIL r1_press_levelup got=%0d want=1", state_a); end
      tick(1);
      total++; if (level_a !== 5'd2) begin bad++; $display("FAIL level_two got=%0d want=2", level_a); end
      for (int e = 0; e < 2; e++) begin
         for (int c = 0; c < 4; c++) begin
            total++; if (lamp_a !== oh3(seq_a[e])) begin bad++; $display("FAIL r2_lamp_on el=%0d cyc=%0d got=%b want=%b", e, c, lamp_a, oh3(seq_a[e])); end
            tick(1);
         end
         for (int c = 0; c < 2; c++) begin
            total++; if (lamp_a !== 3'b000) begin bad++; $display("FAIL r2_lamp_off el=%0d cyc=%0d got=%b want=000", e, c, lamp_a); end
            tick(1);
         end
      end
      total++; if (state_a !== 3'd4) begin bad++; $display("FAIL r2_wait_after_12 got=%0d want=4", state_a); end
   endtask

   task automatic test_wrong_colour;
      btn_a = oh3(seq_a[0]);
      tick(1);
      btn_a = '0;
      total++; if (state_a !== 3'd4 || lose_a !== 1'b0) begin bad++; $display("FAIL first_press_ok got state=%0d lose=%0b want state=4 lose=0", state_a, lose_a); end
      btn_a = oh3((seq_a[1] + 1) % 3);
      tick(1);
      btn_a = '0;
      total++; if (lose_a !== 1'b1) begin bad++; $display("FAIL wrong_lose got=%0b want=1", lose_a); end
      total++; if (state_a !== 3'd6) begin bad++; $display("FAIL wrong_state got=%0d want=6", state_a); end
      total++; if (level_a !== 5'd2) begin bad++; $display("FAIL wrong_level got=%0d want=2", level_a); end
      total++; if (busy_a !== 1'b0 || lamp_a !== 3'b000) begin bad++; $display("FAIL wrong_busy_lamp got busy=%0b lamp=%b want 0 000", busy_a, lamp_a); end
      btn_a = 3'b001; tick(1);
      btn_a = 3'b010; tick(1);
      btn_a = 3'b100; tick(1);
      btn_a = '0;
      total++; if (state_a !== 3'd6 || level_a !== 5'd2 || lose_a !== 1'b1) begin bad++; $display("FAIL lose_holds got state=%0d level=%0d lose=%0b want 6 2 1", state_a, level_a, lose_a); end
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      seq_a[0] = elem(m_lfsr, 3);
      total++; if (lose_a !== 1'b0 || state_a !== 3'd1) begin bad++; $display("FAIL restart got lose=%0b state=%0d want 0 1", lose_a, state_a); end
      tick(1);
      total++; if (level_a !== 5'd1) begin bad++; $display("FAIL restart_level got=%0d want=1", level_a); end
      tick(6);
      total++; if (state_a !== 3'd4) begin bad++; $display("FAIL restart_wait got=%0d want=4", state_a); end
   endtask

   task automatic test_timeout;
      btn_a = oh3(seq_a[0]);
      tick(1);
      btn_a = '0;
      seq_a[1] = elem(m_lfsr, 3);
      tick(13);
      total++; if (state_a !== 3'd4 || level_a !== 5'd2) begin bad++; $display("FAIL to_setup got state=%0d level=%0d want 4 2", state_a, level_a); end
      tick(61);
      total++; if (state_a !== 3'd4) begin bad++; $display("FAIL to_idle61 got=%0d want=4", state_a); end
      btn_a = oh3(seq_a[0]);
      tick(1);
      btn_a = '0;
      total++; if (state_a !== 3'd4 || lose_a !== 1'b0) begin bad++; $display("FAIL to_press62 got state=%0d lose=%0b want 4 0", state_a, lose_a); end
      tick(62);
      total++; if (state_a !== 3'd4 || lose_a !== 1'b0) begin bad++; $display("FAIL to_idle62 got state=%0d lose=%0b want 4 0", state_a, lose_a); end
      tick(1);
      total++; if (state_a !== 3'd6 || lose_a !== 1'b1) begin bad++; $display("FAIL to_idle63 got state=%0d lose=%0b want 6 1", state_a, lose_a); end
   endtask

   task automatic test_win;
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      seq_b[0] = elem(m_lfsr, 4);
      tick(7);
      total++; if (state_b !== 3'd4 || level_b !== 2'd1) begin bad++; $display("FAIL win_r1 got state=%0d level=%0d want 4 1", state_b, level_b); end
      btn_b = oh4(seq_b[0]);
      tick(1);
      btn_b = '0;
      seq_b[1] = elem(m_lfsr, 4);
      tick(13);
      total++; if (state_b !== 3'd4 || level_b !== 2'd2) begin bad++; $display("FAIL win_r2 got state=%0d level=%0d want 4 2", state_b, level_b); end
      btn_b = oh4(seq_b[0]);
      tick(1);
      btn_b = oh4(seq_b[1]);
      tick(1);
      btn_b = '0;
      total++; if (win_b !== 1'b1 || state_b !== 3'd5) begin bad++; $display("FAIL win_flag got win=%0b state=%0d want 1 5", win_b, state_b); end
      total++; if (lamp_b !== 4'b1111) begin bad++; $display("FAIL win_lamp got=%b want=1111", lamp_b); end
      total++; if (level_b !== 2'd2 || busy_b !== 1'b0) begin bad++; $display("FAIL win_level_busy got level=%0d busy=%0b want 2 0", level_b, busy_b); end
   endtask

   task automatic test_multi_bit;
      start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      seq_b[0] = elem(m_lfsr, 4);
      total++; if (win_b !== 1'b0 || level_b !== 2'd0) begin bad++; $display("FAIL mb_restart got win=%0b level=%0d want 0 0", win_b, level_b); end
      tick(7);
      btn_b = oh4(seq_b[0]) | oh4((seq_b[0] + 1) % 4);
      tick(1);
      btn_b = '0;
      total++; if (lose_b !== 1'b1 || state_b !== 3'd6) begin bad++; $display("FAIL mb_lose got lose=%0b state=%0d want 1 6", lose_b, state_b); end
   endtask

   task automatic test_start_ignored;
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      seq_a[0] = elem(m_lfsr, 3);
      tick(5);
      total++; if (state_a !== 3'd3) begin bad++; $display("FAIL si_in_off got=%0d want=3", state_a); end
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      total++; if (state_a !== 3'd3 || level_a !== 5'd1 || lamp_a !== 3'b000) begin bad++; $display("FAIL si_ignored got state=%0d level=%0d lamp=%b want 3 1 000", state_a, level_a, lamp_a); end
      tick(1);
      total++; if (state_a !== 3'd4) begin bad++; $display("FAIL si_wait got=%0d want=4", state_a); end
   endtask

   task automatic test_range;
      for (int it = 0; it < 1000; it++) begin
         btn_a = oh3((seq_a[0] + 1) % 3);
         tick(1);
         btn_a = '0;
         start_a = 1'b1;
         tick(1);
         start_a = 1'b0;
         seq_a[0] = elem(m_lfsr, 3);
         tick(1);
         total++; if (lamp_a === 3'b000 || lamp_a !== oh3(seq_a[0])) begin bad++; $display("FAIL range it=%0d got=%b want=%b", it, lamp_a, oh3(seq_a[0])); end
         tick(6);
      end
      total++; if (state_a !== 3'd4) begin bad++; $display("FAIL range_end got=%0d want=4", state_a); end
   endtask

   task automatic test_async_reset;
      btn_a = oh3(seq_a[0]);
      tick(1);
      btn_a = '0;
      tick(2);
      total++; if (state_a !== 3'd2 || lamp_a === 3'b000) begin bad++; $display("FAIL ar_pre got state=%0d lamp=%b want state=2 lamp!=0", state_a, lamp_a); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (lamp_a !== 3'b000 || state_a !== 3'd0) begin bad++; $display("FAIL ar_async got lamp=%b state=%0d want 000 0", lamp_a, state_a); end
      total++; if (level_a !== 5'd0 || busy_a !== 1'b0) begin bad++; $display("FAIL ar_level_busy got level=%0d busy=%0b want 0 0", level_a, busy_a); end
      tick(1);
      reset_n = 1'b1;
      tick(2);
      total++; if (state_a !== 3'd0 || lamp_a !== 3'b000) begin bad++; $display("FAIL ar_after got state=%0d lamp=%b want 0 000", state_a, lamp_a); end
   endtask

   initial begin
      test_reset;
      test_playback;
      test_wrong_colour;
      test_timeout;
      test_win;
      test_multi_bit;
      test_start_ignored;
      test_range;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
